// File: rtl/flex_updown_counter.sv
// Up/down counter with a runtime-programmable rollover value, parallel load and a registered wrap pulse.
// Optional wrap-event counter output enabled by defining ROLL_COUNT_EN.
module flex_updown_counter #(
  parameter int NUM_BITS  = 4,
  parameter int ROLL_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [NUM_BITS-1:0]  load_val,
  input  logic                 count_enable,
  input  logic                 count_down,
  input  logic [NUM_BITS-1:0]  rollover_val,
  output logic [NUM_BITS-1:0]  count_out,
  output logic                 rollover_flag,
  output logic                 wrap_pulse
`ifdef ROLL_COUNT_EN
  ,
  output logic [ROLL_BITS-1:0] roll_count
`endif
);

  if (NUM_BITS < 2 || NUM_BITS > 32 || ROLL_BITS < 1) begin : g_bad_param
    $error("flex_updown_counter: illegal NUM_BITS/ROLL_BITS");
  end

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] cnt_d, cnt_q;
  logic [NUM_BITS-1:0] wrap_pt;
  logic                flag_d, flag_q;
  logic                pulse_d, pulse_q;
  logic                roll_zero;

  assign roll_zero = (rollover_val == '0);

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (count_enable && !roll_zero) begin
      if (!count_down) begin
        if (cnt_q >= rollover_val) begin
          cnt_d   = ONE;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        // Anything at or below 1, or stranded above R by a load, reloads R.
        if (cnt_q <= ONE || cnt_q > rollover_val) begin
          cnt_d   = rollover_val;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
    // Flag is precomputed from the next count so it lines up with count_out.
    wrap_pt = count_down ? ONE : rollover_val;
    flag_d  = !roll_zero && (cnt_d == wrap_pt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_out     = cnt_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;

`ifdef ROLL_COUNT_EN
  logic [ROLL_BITS-1:0] roll_d, roll_q;

  always_comb begin
    roll_d = roll_q;
    if (clear)        roll_d = '0;
    else if (pulse_d) roll_d = roll_q + ROLL_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) roll_q <= '0;
    else     roll_q <= roll_d;
  end

  assign roll_count = roll_q;
`endif

endmodule

// File: tb/tb_flex_updown_counter.sv
// Scoreboard bench for flex_updown_counter: directed steps push hand-computed expectations, a monitor checks each edge.
module tb_flex_updown_counter;
  logic       clk;
  logic       rst, clear, load, count_enable, count_down;
  logic [3:0] load_val, rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag, wrap_pulse;
`ifdef ROLL_COUNT_EN
  logic [7:0] roll_count;
`endif

  flex_updown_counter #(.NUM_BITS(4), .ROLL_BITS(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .rollover_val(rollover_val),
    .count_out(count_out), .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse)
`ifdef ROLL_COUNT_EN
    , .roll_count(roll_count)
`endif
  );

  typedef struct {
    logic [3:0] c;
    logic       f;
    logic       p;
    logic [7:0] r;
    int         id;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         step_id  = 0;
  logic [7:0] exp_roll = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic r, input logic clr, input logic ld, input logic [3:0] lv,
                      input logic en, input logic dn, input logic [3:0] rv,
                      input logic [3:0] ec, input logic ef, input logic ep);
    exp_t e;
    @(negedge clk);
    rst = r; clear = clr; load = ld; load_val = lv;
    count_enable = en; count_down = dn; rollover_val = rv;
    if (r || clr) exp_roll = 8'd0;
    else if (ep)  exp_roll = exp_roll + 8'd1;
    e.c = ec; e.f = ef; e.p = ep; e.r = exp_roll; e.id = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (count_out !== e.c) begin
          n_fail++;
          $display("FAIL count step %0d: got %0d want %0d", e.id, count_out, e.c);
        end
        n_checks++;
        if (rollover_flag !== e.f) begin
          n_fail++;
          $display("FAIL flag step %0d: got %b want %b", e.id, rollover_flag, e.f);
        end
        n_checks++;
        if (wrap_pulse !== e.p) begin
          n_fail++;
          $display("FAIL pulse step %0d: got %b want %b", e.id, wrap_pulse, e.p);
        end
`ifdef ROLL_COUNT_EN
        n_checks++;
        if (roll_count !== e.r) begin
          n_fail++;
          $display("FAIL roll_count step %0d: got %0d want %0d", e.id, roll_count, e.r);
        end
`endif
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
    count_enable = 1'b0; count_down = 1'b0; rollover_val = 4'd5;

    // Reset held 2 edges while enabled, then count to R=5 and wrap.
    step(1,0,0,0,1,0,5, 0,0,0);
    step(1,0,0,0,1,0,5, 0,0,0);
    step(0,0,0,0,1,0,5, 1,0,0);
    step(0,0,0,0,1,0,5, 2,0,0);
    step(0,0,0,0,1,0,5, 3,0,0);
    step(0,0,0,0,1,0,5, 4,0,0);
    step(0,0,0,0,1,0,5, 5,1,0);
    step(0,0,0,0,1,0,5, 1,0,1);

    // R=7 with an enable gap at 4.
    step(0,1,0,0,1,0,7, 0,0,0);
    step(0,0,0,0,1,0,7, 1,0,0);
    step(0,0,0,0,1,0,7, 2,0,0);
    step(0,0,0,0,1,0,7, 3,0,0);
    step(0,0,0,0,1,0,7, 4,0,0);
    step(0,0,0,0,0,0,7, 4,0,0);
    step(0,0,0,0,0,0,7, 4,0,0);
    step(0,0,0,0,1,0,7, 5,0,0);
    step(0,0,0,0,1,0,7, 6,0,0);
    step(0,0,0,0,1,0,7, 7,1,0);
    step(0,0,0,0,1,0,7, 1,0,1);

    // R=6 counting down from reset.
    step(1,0,0,0,1,1,6, 0,0,0);
    step(0,0,0,0,1,1,6, 6,0,1);
    step(0,0,0,0,1,1,6, 5,0,0);
    step(0,0,0,0,1,1,6, 4,0,0);
    step(0,0,0,0,1,1,6, 3,0,0);
    step(0,0,0,0,1,1,6, 2,0,0);
    step(0,0,0,0,1,1,6, 1,1,0);
    step(0,0,0,0,1,1,6, 6,0,1);

    // Full-range R=15, then clear beats load.
    step(1,0,0,0,1,0,15, 0,0,0);
    for (int i = 1; i <= 15; i++)
      step(0,0,0,0,1,0,15, 4'(i), (i == 15), 0);
    step(0,0,0,0,1,0,15, 1,0,1);
    step(0,1,1,9,1,0,15, 0,0,0);

    // Load above R, wrap from there, reset mid-count.
    step(0,0,0,0,1,0,10, 1,0,0);
    step(0,0,0,0,1,0,10, 2,0,0);
    step(0,0,0,0,1,0,10, 3,0,0);
    step(0,0,1,12,1,0,10, 12,0,0);
    step(0,0,0,0,1,0,10, 1,0,1);
    for (int i = 2; i <= 7; i++)
      step(0,0,0,0,1,0,10, 4'(i),0,0);
    step(1,0,0,0,1,0,10, 0,0,0);

    // R=0 suppresses counting and the flag; load still acts.
    step(0,0,1,5,0,0,0, 5,0,0);
    step(0,0,0,0,1,0,0, 5,0,0);
    step(0,0,0,0,1,1,0, 5,0,0);

    // R=1 up: 0, 1, 1 with pulses after the first step.
    step(0,1,0,0,0,0,1, 0,0,0);
    step(0,0,0,0,1,0,1, 1,1,0);
    step(0,0,0,0,1,0,1, 1,1,1);
    step(0,0,0,0,1,0,1, 1,1,1);

    // Direction change while holding moves the flag; down from above R reloads R.
    step(0,0,1,1,0,0,5, 1,0,0);
    step(0,0,0,0,0,1,5, 1,1,0);
    step(0,0,1,9,0,1,5, 9,0,0);
    step(0,0,0,0,1,1,5, 5,0,1);

    // R=2 up for 10 steps from reset: four wraps; load leaves the wrap count alone.
    step(1,0,0,0,0,0,2, 0,0,0);
    step(0,0,0,0,1,0,2, 1,0,0);
    step(0,0,0,0,1,0,2, 2,1,0);
    step(0,0,0,0,1,0,2, 1,0,1);
    step(0,0,0,0,1,0,2, 2,1,0);
    step(0,0,0,0,1,0,2, 1,0,1);
    step(0,0,0,0,1,0,2, 2,1,0);
    step(0,0,0,0,1,0,2, 1,0,1);
    step(0,0,0,0,1,0,2, 2,1,0);
    step(0,0,0,0,1,0,2, 1,0,1);
    step(0,0,0,0,1,0,2, 2,1,0);
    step(0,0,1,3,0,0,2, 3,0,0);
    step(0,1,0,0,0,0,2, 0,0,0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
- Parametrised successor to the team's flex counter: NUM_BITS-wide, runtime-programmable rollover, up/down direction, parallel load, and a registered wrap pulse.
- Serves as the shared timing and counting primitive for the bit-period timers, byte counters and FIFO pointers in the serial and datapath blocks.
- Single clock domain; all outputs are registered.

Parameters:
- NUM_BITS, 4, width of count_out, rollover_val and load_val; legal range 2..32.
- ROLL_BITS, 8, width of roll_count; used only when ROLL_COUNT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear of count to 0.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  NUM_BITS  value loaded when load=1.
- count_enable  input  1  advance one step per cycle while high.
- count_down  input  1  0 = count up, 1 = count down; sampled each enabled cycle.
- rollover_val  input  NUM_BITS  wrap value, programmable at runtime.
- count_out  output  NUM_BITS  current count.
- rollover_flag  output  1  high while count_out equals the current wrap point.
- wrap_pulse  output  1  one-cycle pulse on each enabled step that wrapped.
- roll_count  output  ROLL_BITS  wrap event counter; present only with ROLL_COUNT_EN.

Behaviour:
- Reset: rst=1 at a rising edge forces count_out=0, rollover_flag=0, wrap_pulse=0 and roll_count=0. Reset overrides every other input.
- Priority, per edge: rst > clear > load > count_enable. With none active, count_out holds.
- clear: next count_out=0; wrap_pulse=0.
- load: next count_out=load_val, any value including above rollover_val; wrap_pulse=0.
- Step rules (let R = rollover_val):
  - Up step: if count_out >= R, next=1 and wrap_pulse=1; otherwise next=count_out+1.
  - Down step: if count_out <= 1 or count_out > R, next=R and wrap_pulse=1; otherwise next=count_out-1.
- R=0: counting is suppressed. count_out holds, wrap_pulse=0, rollover_flag=0. clear and load still act.
- R=1, up mode: the sequence is 0, 1, 1, 1, …, with wrap_pulse=1 on every enabled step after the first.
- Wrap point: R in up mode, 1 in down mode.
- rollover_flag is registered. It equals (next count_out == wrap point) evaluated with that edge's count_down, so it is valid in the same cycle as count_out.
- When count_down changes while count holds, rollover_flag updates at the next edge.
- When R changes mid-count, the new R applies from the next edge.
- There is no combinational path from any input to any output. Latency is one edge.

Optional Feature:
- Macro: ROLL_COUNT_EN.
- Defined:
  - roll_count increments by 1 on each edge that produces wrap_pulse=1, and wraps modulo 2^ROLL_BITS.
  - clear and rst zero it; load does not affect it.
- Undefined: the roll_count port and its logic are absent. All other behaviour is identical.

Test Plan:
- rst=1 for 2 edges with count_enable=1, R=5 -> count_out=0, flag=0, pulse=0 throughout; after rst=0, count_out steps 1, 2, 3, 4, 5 (flag=1 at 5), then 1 with pulse=1 in that cycle.
- R=7, up; drop count_enable at count 4 for 2 cycles, then re-enable -> count 4, 4, 4, 5, 6, 7 with flag=1 at 7; the next step gives 1 and pulse=1.
- R=6, count_down=1 from reset -> 6 (pulse=1), 5, 4, 3, 2, 1 (flag=1), then 6 (pulse=1).
- NUM_BITS=4, R=15, up from reset -> 1 … 15 with flag at 15, then 1; separately, load=1 and clear=1 in the same cycle -> count_out=0.
- At count 3, load=1 with load_val=12 and R=10, then enable up -> next count 12, then 1 with pulse=1; assert rst mid-count at 7 -> 0 on that edge.
- ROLL_COUNT_EN defined, R=2, up for 10 enabled steps from reset -> roll_count=4; clear -> roll_count=0.
